// File: rtl/fetch_redirect_unit.sv
// Fetch stage: owns the PC, keeps at most one instruction-memory request in flight, and feeds IF/ID.
// Optional performance counters are enabled with `define FETCH_PERF_CNT_EN.
module fetch_redirect_unit #(
    parameter int unsigned          PC_W     = 9,
    parameter logic [PC_W-1:0]      RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pc_sel,
    input  logic [31:0]     branch_target,
    input  logic            stall,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            if_id_valid,
    output logic [PC_W-1:0] if_id_pc,
    output logic [31:0]     if_id_instr,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_dropped
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_HOLD
    } state_t;

    localparam logic [PC_W-1:0] PC_INC = PC_W'(4);

    state_t            r_state;
    logic [PC_W-1:0]   r_pc;
    logic              r_drop;
    logic [PC_W-1:0]   r_redirect_pc;
    logic              r_skid_valid;
    logic [PC_W-1:0]   r_skid_pc;
    logic [31:0]       r_skid_instr;
    logic              r_if_id_valid;
    logic [PC_W-1:0]   r_if_id_pc;
    logic [31:0]       r_if_id_instr;

    state_t            w_state_nxt;
    logic [PC_W-1:0]   w_pc_nxt;
    logic              w_drop_nxt;
    logic [PC_W-1:0]   w_redirect_pc_nxt;
    logic              w_skid_valid_nxt;
    logic [PC_W-1:0]   w_skid_pc_nxt;
    logic [31:0]       w_skid_instr_nxt;
    logic              w_if_id_valid_nxt;
    logic [PC_W-1:0]   w_if_id_pc_nxt;
    logic [31:0]       w_if_id_instr_nxt;
    logic              w_fetch_inc;
    logic              w_drop_inc;
    logic [PC_W-1:0]   w_target;

    assign w_target = {branch_target[PC_W-1:2], 2'b00};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_PC;
            r_drop        <= 1'b0;
            r_redirect_pc <= '0;
            r_skid_valid  <= 1'b0;
            r_skid_pc     <= '0;
            r_skid_instr  <= '0;
            r_if_id_valid <= 1'b0;
            r_if_id_pc    <= '0;
            r_if_id_instr <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_drop        <= w_drop_nxt;
            r_redirect_pc <= w_redirect_pc_nxt;
            r_skid_valid  <= w_skid_valid_nxt;
            r_skid_pc     <= w_skid_pc_nxt;
            r_skid_instr  <= w_skid_instr_nxt;
            r_if_id_valid <= w_if_id_valid_nxt;
            r_if_id_pc    <= w_if_id_pc_nxt;
            r_if_id_instr <= w_if_id_instr_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_drop_nxt        = r_drop;
        w_redirect_pc_nxt = r_redirect_pc;
        w_skid_valid_nxt  = r_skid_valid;
        w_skid_pc_nxt     = r_skid_pc;
        w_skid_instr_nxt  = r_skid_instr;
        w_if_id_valid_nxt = r_if_id_valid;
        w_if_id_pc_nxt    = r_if_id_pc;
        w_if_id_instr_nxt = r_if_id_instr;
        w_fetch_inc       = 1'b0;
        w_drop_inc        = 1'b0;

        // ID consumes IF/ID whenever it is not stalled; a bubble follows unless a load below overrides it
        if (!stall) begin
            w_if_id_valid_nxt = 1'b0;
        end

        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_REQ;
                if (pc_sel) begin
                    w_pc_nxt = w_target;
                end
            end
            S_REQ: begin
                if (imem_rvalid) begin
                    if (pc_sel || r_drop) begin
                        w_drop_inc = 1'b1;
                        w_drop_nxt = 1'b0;
                        w_pc_nxt   = pc_sel ? w_target : r_redirect_pc;
                    end else if (!stall) begin
                        w_if_id_valid_nxt = 1'b1;
                        w_if_id_pc_nxt    = r_pc;
                        w_if_id_instr_nxt = imem_rdata;
                        w_fetch_inc       = 1'b1;
                        w_pc_nxt          = r_pc + PC_INC;
                    end else begin
                        w_skid_valid_nxt = 1'b1;
                        w_skid_pc_nxt    = r_pc;
                        w_skid_instr_nxt = imem_rdata;
                        w_pc_nxt         = r_pc + PC_INC;
                        w_state_nxt      = S_HOLD;
                    end
                end else if (pc_sel) begin
                    // keep the address stable until the in-flight response retires
                    w_drop_nxt        = 1'b1;
                    w_redirect_pc_nxt = w_target;
                end
            end
            S_HOLD: begin
                if (pc_sel) begin
                    w_pc_nxt    = w_target;
                    w_state_nxt = S_REQ;
                end else if (!stall) begin
                    w_if_id_valid_nxt = r_skid_valid;
                    w_if_id_pc_nxt    = r_skid_pc;
                    w_if_id_instr_nxt = r_skid_instr;
                    w_fetch_inc       = r_skid_valid;
                    w_skid_valid_nxt  = 1'b0;
                    w_state_nxt       = S_REQ;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (pc_sel) begin
            w_if_id_valid_nxt = 1'b0;
            w_skid_valid_nxt  = 1'b0;
        end
    end

    assign imem_req    = (r_state == S_REQ);
    assign imem_addr   = r_pc;
    assign if_id_valid = r_if_id_valid;
    assign if_id_pc    = r_if_id_pc;
    assign if_id_instr = r_if_id_instr;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_dropped;
    logic        w_unused;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_fetched <= '0;
            r_perf_dropped <= '0;
        end else begin
            if (w_fetch_inc && (r_perf_fetched != '1)) begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end
            if (w_drop_inc && (r_perf_dropped != '1)) begin
                r_perf_dropped <= r_perf_dropped + 32'd1;
            end
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_dropped = r_perf_dropped;
    assign w_unused     = &{1'b0, branch_target[31:PC_W], branch_target[1:0]};
`else
    logic w_unused;

    assign perf_fetched = '0;
    assign perf_dropped = '0;
    assign w_unused     = &{1'b0, branch_target[31:PC_W], branch_target[1:0], w_fetch_inc, w_drop_inc};
`endif

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Self-checking bench for fetch_redirect_unit: cycle vector table, directed redirect/reset
// sequences, and a randomized run checked against an instruction-stream reference model.
module tb_fetch_redirect_unit;

    localparam int unsigned PC_W = 9;
`ifdef FETCH_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic            pc_sel;
    logic [31:0]     branch_target;
    logic            stall;
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;
    logic            if_id_valid;
    logic [PC_W-1:0] if_id_pc;
    logic [31:0]     if_id_instr;
    logic [31:0]     perf_fetched;
    logic [31:0]     perf_dropped;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_redirect_unit #(.PC_W(PC_W), .RESET_PC(9'h000)) dut (
        .clk          (clk),
        .reset        (reset),
        .pc_sel       (pc_sel),
        .branch_target(branch_target),
        .stall        (stall),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .if_id_valid  (if_id_valid),
        .if_id_pc     (if_id_pc),
        .if_id_instr  (if_id_instr),
        .perf_fetched (perf_fetched),
        .perf_dropped (perf_dropped)
    );

    typedef struct {
        logic            rst;
        logic            ps;
        logic [31:0]     tgt;
        logic            st;
        logic            rv;
        logic [31:0]     rd;
        logic            e_req;
        logic [PC_W-1:0] e_addr;
        logic            e_v;
        logic [PC_W-1:0] e_pc;
        logic [31:0]     e_instr;
    } vec_t;

    vec_t vq[$];

    function automatic logic [31:0] memw(input logic [PC_W-1:0] a);
        return 32'hC0DE_0000 | {23'd0, a};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic p, input logic [31:0] t, input logic s,
                         input logic v, input logic [31:0] d);
        reset         = r;
        pc_sel        = p;
        branch_target = t;
        stall         = s;
        imem_rvalid   = v;
        imem_rdata    = d;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic rst, input logic ps, input logic [31:0] tgt, input logic st,
                       input logic rv, input logic [31:0] rd, input logic e_req,
                       input logic [PC_W-1:0] e_addr, input logic e_v,
                       input logic [PC_W-1:0] e_pc, input logic [31:0] e_instr);
        vec_t v;
        v.rst = rst; v.ps = ps; v.tgt = tgt; v.st = st; v.rv = rv; v.rd = rd;
        v.e_req = e_req; v.e_addr = e_addr; v.e_v = e_v; v.e_pc = e_pc; v.e_instr = e_instr;
        vq.push_back(v);
    endtask

    // Single-step helper for hand sequences: no redirect, no stall
    task automatic idle(input logic v, input logic [31:0] d);
        drive(1'b0, 1'b0, 32'd0, 1'b0, v, d);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        logic [PC_W-1:0] exp_next;
        logic            p_req;
        logic [PC_W-1:0] p_addr;
        logic            p_v;
        logic [PC_W-1:0] p_pc;
        logic [31:0]     p_instr;
        int              deliveries;
        int              mcnt;
        int              mlat;
        logic            ps;
        logic            st;
        logic            rv;
        logic [31:0]     tgt;
        logic [31:0]     rd;

        // rst ps tgt st rv rdata | req addr valid pc instr
        add(1, 0, 0,      0, 0, 0,             0, 9'h000, 0, 9'h000, 32'h0);
        add(1, 0, 0,      0, 0, 0,             0, 9'h000, 0, 9'h000, 32'h0);
        add(0, 0, 0,      0, 0, 0,             1, 9'h000, 0, 9'h000, 32'h0);
        add(0, 0, 0,      0, 0, 0,             1, 9'h000, 0, 9'h000, 32'h0);
        add(0, 0, 0,      0, 1, memw(9'h000),  1, 9'h004, 1, 9'h000, memw(9'h000));
        add(0, 0, 0,      0, 0, 0,             1, 9'h004, 0, 9'h000, memw(9'h000));
        add(0, 0, 0,      0, 1, memw(9'h004),  1, 9'h008, 1, 9'h004, memw(9'h004));
        add(0, 0, 0,      0, 0, 0,             1, 9'h008, 0, 9'h004, memw(9'h004));
        add(0, 0, 0,      0, 1, memw(9'h008),  1, 9'h00C, 1, 9'h008, memw(9'h008));
        add(0, 0, 0,      1, 0, 0,             1, 9'h00C, 1, 9'h008, memw(9'h008));
        add(0, 0, 0,      1, 1, memw(9'h00C),  0, 9'h000, 1, 9'h008, memw(9'h008));
        add(0, 0, 0,      1, 0, 0,             0, 9'h000, 1, 9'h008, memw(9'h008));
        add(0, 0, 0,      1, 0, 0,             0, 9'h000, 1, 9'h008, memw(9'h008));
        add(0, 0, 0,      1, 0, 0,             0, 9'h000, 1, 9'h008, memw(9'h008));
        add(0, 0, 0,      0, 0, 0,             1, 9'h010, 1, 9'h00C, memw(9'h00C));
        add(0, 0, 0,      0, 0, 0,             1, 9'h010, 0, 9'h00C, memw(9'h00C));
        add(0, 0, 0,      0, 1, memw(9'h010),  1, 9'h014, 1, 9'h010, memw(9'h010));
        add(0, 1, 32'h1FC, 0, 0, 0,            1, 9'h014, 0, 9'h010, memw(9'h010));
        add(0, 0, 0,      0, 1, memw(9'h014),  1, 9'h1FC, 0, 9'h010, memw(9'h010));
        add(0, 0, 0,      0, 0, 0,             1, 9'h1FC, 0, 9'h010, memw(9'h010));
        add(0, 0, 0,      0, 1, memw(9'h1FC),  1, 9'h000, 1, 9'h1FC, memw(9'h1FC));
        add(0, 0, 0,      0, 0, 0,             1, 9'h000, 0, 9'h1FC, memw(9'h1FC));
        add(0, 0, 0,      0, 1, memw(9'h000),  1, 9'h004, 1, 9'h000, memw(9'h000));

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].rst, vq[i].ps, vq[i].tgt, vq[i].st, vq[i].rv, vq[i].rd);
            chk($sformatf("vec%0d.req", i), imem_req, vq[i].e_req);
            if (vq[i].e_req || vq[i].rst)
                chk($sformatf("vec%0d.addr", i), imem_addr, vq[i].e_addr);
            chk($sformatf("vec%0d.valid", i), if_id_valid, vq[i].e_v);
            chk($sformatf("vec%0d.pc", i), if_id_pc, vq[i].e_pc);
            chk($sformatf("vec%0d.instr", i), if_id_instr, vq[i].e_instr);
        end

        // Redirect while a 3-cycle response is outstanding
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        chk("rst.perf_fetched", perf_fetched, 0);
        chk("rst.perf_dropped", perf_dropped, 0);
        idle(0, 0);
        idle(0, 0);
        idle(1, memw(9'h000));
        chk("h1.first_valid", if_id_valid, 1);
        drive(0, 1, 32'h40, 0, 0, 0);
        chk("h1.flush_valid", if_id_valid, 0);
        chk("h1.addr_held", imem_addr, 9'h004);
        idle(0, 0);
        idle(0, 0);
        idle(1, memw(9'h004));
        chk("h1.stale_valid", if_id_valid, 0);
        chk("h1.new_addr", imem_addr, 9'h040);
        chk("h1.perf_dropped", perf_dropped, PERF ? 1 : 0);
        idle(0, 0);
        idle(1, memw(9'h040));
        chk("h1.tgt_valid", if_id_valid, 1);
        chk("h1.tgt_pc", if_id_pc, 9'h040);
        chk("h1.tgt_instr", if_id_instr, memw(9'h040));
        chk("h1.perf_fetched", perf_fetched, PERF ? 2 : 0);

        // Redirect coincident with response and stall: flush wins
        idle(0, 0);
        drive(0, 1, 32'h22, 1, 1, memw(9'h044));
        chk("h2.valid", if_id_valid, 0);
        chk("h2.req", imem_req, 1);
        chk("h2.addr", imem_addr, 9'h020);
        chk("h2.perf_dropped", perf_dropped, PERF ? 2 : 0);
        idle(0, 0);
        idle(1, memw(9'h020));
        chk("h2.tgt_pc", if_id_pc, 9'h020);
        chk("h2.tgt_valid", if_id_valid, 1);

        // Back-to-back redirects: last target wins
        drive(0, 1, 32'h80, 0, 0, 0);
        drive(0, 1, 32'h104, 0, 0, 0);
        idle(1, memw(9'h024));
        chk("h4.addr", imem_addr, 9'h104);
        chk("h4.valid", if_id_valid, 0);
        idle(0, 0);
        idle(1, memw(9'h104));
        chk("h4.pc", if_id_pc, 9'h104);
        chk("h4.instr", if_id_instr, memw(9'h104));
        chk("h4.perf_fetched", perf_fetched, PERF ? 4 : 0);
        chk("h4.perf_dropped", perf_dropped, PERF ? 3 : 0);

        // Reset mid-request, then a late response
        idle(0, 0);
        drive(1, 0, 0, 0, 0, 0);
        chk("h3.req", imem_req, 0);
        chk("h3.addr", imem_addr, 9'h000);
        chk("h3.valid", if_id_valid, 0);
        chk("h3.pc", if_id_pc, 9'h000);
        chk("h3.instr", if_id_instr, 0);
        chk("h3.perf_fetched", perf_fetched, 0);
        drive(0, 0, 0, 0, 1, 32'hDEADBEEF);
        chk("h3.late_req", imem_req, 1);
        chk("h3.late_addr", imem_addr, 9'h000);
        chk("h3.late_valid", if_id_valid, 0);
        chk("h3.late_perf_dropped", perf_dropped, 0);
        idle(0, 0);
        idle(1, memw(9'h000));
        chk("h3.restart_pc", if_id_pc, 9'h000);
        chk("h3.restart_instr", if_id_instr, memw(9'h000));

        // Randomized run: model tracks only the expected program-order instruction stream
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        exp_next   = 9'h000;
        deliveries = 0;
        mcnt       = 0;
        mlat       = 1;
        p_req = imem_req; p_addr = imem_addr;
        p_v = if_id_valid; p_pc = if_id_pc; p_instr = if_id_instr;
        for (int n = 0; n < 3000; n++) begin
            ps  = ($urandom_range(0, 15) == 0);
            st  = ($urandom_range(0, 3) == 0);
            tgt = $urandom();
            rv  = 1'b0;
            rd  = 32'd0;
            if (imem_req) begin
                mcnt++;
                if (mcnt > mlat) begin
                    rv   = 1'b1;
                    rd   = memw(imem_addr);
                    mcnt = 0;
                    mlat = $urandom_range(1, 3);
                end
            end else begin
                mcnt = 0;
            end
            drive(0, ps, tgt, st, rv, rd);
            if (p_req && !rv) begin
                chk("rnd.req_held", imem_req, 1);
                chk("rnd.addr_stable", imem_addr, p_addr);
            end
            if (ps) begin
                chk("rnd.flush", if_id_valid, 0);
                exp_next = tgt[PC_W-1:0] & ~9'h003;
            end else if (st) begin
                chk("rnd.stall_hold", {if_id_valid, if_id_pc, if_id_instr}, {p_v, p_pc, p_instr});
            end else if (if_id_valid) begin
                chk("rnd.pc", if_id_pc, exp_next);
                chk("rnd.instr", if_id_instr, memw(if_id_pc));
                exp_next = exp_next + 9'd4;
                deliveries++;
            end
            p_req = imem_req; p_addr = imem_addr;
            p_v = if_id_valid; p_pc = if_id_pc; p_instr = if_id_instr;
        end
        chk("rnd.progress", deliveries >= 50, 1);
        chk("rnd.perf_fetched", perf_fetched, PERF ? deliveries : 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
